// File: rtl/ring_pkg.sv
// Shared types and default parameters for the ring-counter decoder.
package ring_pkg;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    TRACK  = 2'd1,
    LOCKED = 2'd2
  } ring_state_e;

  localparam int DEF_WIDTH    = 4;
  localparam int DEF_LOCK_CNT = 3;
  localparam int DEF_ERR_W    = 8;

  // Bits needed to hold every value from 0 up to and including maxVal.
  function automatic int cntWidth(input int maxVal);
    return (maxVal < 1) ? 1 : $clog2(maxVal + 1);
  endfunction

endpackage

// File: rtl/ring_onehot_enc.sv
// Combinational one-hot detector and binary position encoder.
module ring_onehot_enc
  import ring_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int IDX_W = $clog2(DEF_WIDTH)
) (
  input  logic [WIDTH-1:0] vec_i,
  output logic             is_onehot_o,
  output logic [IDX_W-1:0] idx_o
);

  localparam int CNT_W = cntWidth(WIDTH);

  logic [CNT_W-1:0] onesCnt;

  // OR-ing positions is only meaningful when exactly one bit is set.
  always_comb begin
    onesCnt = '0;
    idx_o   = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (vec_i[i]) begin
        onesCnt = onesCnt + CNT_W'(1);
        idx_o   = idx_o | IDX_W'(i);
      end
    end
  end

  assign is_onehot_o = (onesCnt == CNT_W'(1));

endmodule

// File: rtl/ring_decode.sv
// Ring-counter decoder: reports the set-bit position, tracks the rotate-left
// sequence, declares lock after LOCK_CNT good steps and counts lock losses.
module ring_decode
  import ring_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int LOCK_CNT = DEF_LOCK_CNT,
  parameter int ERR_W    = DEF_ERR_W
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     en,
  input  logic [WIDTH-1:0]         ring_in,
  input  logic                     clr_err,
  output logic [$clog2(WIDTH)-1:0] idx,
  output logic                     idx_valid,
  output logic                     locked,
  output logic                     seq_err,
  output logic [ERR_W-1:0]         err_cnt
);

  localparam int IDX_W  = $clog2(WIDTH);
  localparam int GOOD_W = cntWidth(LOCK_CNT);
  localparam logic [ERR_W-1:0]  ERR_MAX  = '1;
  localparam logic [GOOD_W-1:0] GOOD_TGT = GOOD_W'(LOCK_CNT);

  ring_state_e       state_q;
  logic [WIDTH-1:0]  prev_q;
  logic [GOOD_W-1:0] goodCnt_q;
  logic [IDX_W-1:0]  idx_q;
  logic              idxValid_q;
  logic              locked_q;
  logic              seqErr_q;
  logic [ERR_W-1:0]  errCnt_q;

  logic              sampleOneHot;
  logic [IDX_W-1:0]  sampleIdx;
  logic [WIDTH-1:0]  rotPrev;
  logic              rotMatch;
  logic [GOOD_W-1:0] goodCnt_d;
  logic              lockLoss;

  ring_onehot_enc #(
    .WIDTH (WIDTH),
    .IDX_W (IDX_W)
  ) u_enc (
    .vec_i       (ring_in),
    .is_onehot_o (sampleOneHot),
    .idx_o       (sampleIdx)
  );

  assign rotPrev   = {prev_q[WIDTH-2:0], prev_q[WIDTH-1]};
  assign rotMatch  = (ring_in == rotPrev);
  assign goodCnt_d = goodCnt_q + GOOD_W'(1);
  assign lockLoss  = en && (state_q == LOCKED) && !rotMatch;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= SEARCH;
      prev_q     <= '0;
      goodCnt_q  <= '0;
      idx_q      <= '0;
      idxValid_q <= 1'b0;
      locked_q   <= 1'b0;
      seqErr_q   <= 1'b0;
      errCnt_q   <= '0;
    end else begin
      seqErr_q <= 1'b0;
      if (en) begin
        idxValid_q <= sampleOneHot;
        if (sampleOneHot) begin
          idx_q <= sampleIdx;
        end
        case (state_q)
          SEARCH: begin
            if (sampleOneHot) begin
              prev_q    <= ring_in;
              goodCnt_q <= '0;
              state_q   <= TRACK;
            end
          end
          TRACK: begin
            if (rotMatch) begin
              prev_q    <= ring_in;
              goodCnt_q <= goodCnt_d;
              if (goodCnt_d == GOOD_TGT) begin
                state_q  <= LOCKED;
                locked_q <= 1'b1;
              end
            end else if (sampleOneHot) begin
              prev_q    <= ring_in;
              goodCnt_q <= '0;
            end else begin
              goodCnt_q <= '0;
              state_q   <= SEARCH;
            end
          end
          LOCKED: begin
            if (rotMatch) begin
              prev_q <= ring_in;
            end else begin
              seqErr_q  <= 1'b1;
              locked_q  <= 1'b0;
              goodCnt_q <= '0;
              if (sampleOneHot) begin
                prev_q  <= ring_in;
                state_q <= TRACK;
              end else begin
                state_q <= SEARCH;
              end
            end
          end
          default: begin
            locked_q <= 1'b0;
            state_q  <= SEARCH;
          end
        endcase
      end
      // A clear wins over a coincident lock loss; the pulse itself still fires.
      if (clr_err) begin
        errCnt_q <= '0;
      end else if (lockLoss && (errCnt_q != ERR_MAX)) begin
        errCnt_q <= errCnt_q + ERR_W'(1);
      end
    end
  end

  assign idx       = idx_q;
  assign idx_valid = idxValid_q;
  assign locked    = locked_q;
  assign seq_err   = seqErr_q;
  assign err_cnt   = errCnt_q;

endmodule

// File: tb/tb_ring_decode.sv
// Scoreboard bench for ring_decode: a sequence-level model predicts each
// cycle's outputs for a default instance and a 2-bit error-counter instance.
module tb_ring_decode;

  localparam int W  = 4;
  localparam int LC = 3;

  logic       clk = 1'b0;
  logic       rstn;
  logic       en;
  logic       clrErr;
  logic [3:0] ringIn;

  logic [1:0] idxA, idxB;
  logic       idxValidA, idxValidB;
  logic       lockedA, lockedB;
  logic       seqErrA, seqErrB;
  logic [7:0] errCntA;
  logic [1:0] errCntB;

  always #5 clk = ~clk;

  ring_decode #(.WIDTH(W), .LOCK_CNT(LC), .ERR_W(8)) dut (
    .clk(clk), .rstn(rstn), .en(en), .ring_in(ringIn), .clr_err(clrErr),
    .idx(idxA), .idx_valid(idxValidA), .locked(lockedA),
    .seq_err(seqErrA), .err_cnt(errCntA)
  );

  ring_decode #(.WIDTH(W), .LOCK_CNT(LC), .ERR_W(2)) dutE2 (
    .clk(clk), .rstn(rstn), .en(en), .ring_in(ringIn), .clr_err(clrErr),
    .idx(idxB), .idx_valid(idxValidB), .locked(lockedB),
    .seq_err(seqErrB), .err_cnt(errCntB)
  );

  typedef struct {
    int idx;
    bit idxValid;
    bit locked;
    bit seqErr;
    int err8;
    int err2;
  } exp_t;

  exp_t expQ[$];
  int   totalChecks = 0;
  int   badChecks   = 0;

  // Model state: position of the last accepted one-hot sample (-1 = none),
  // number of consecutive correct rotations since then, and lock-loss count.
  int mLastIdx, mRun, mErrs, mIdx;
  bit mLocked, mIdxValid;

  task automatic checkOutput(input string name, input int act, input int expv);
    totalChecks++;
    if (act != expv) begin
      badChecks++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    end
  endtask

  function automatic int minInt(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic modelReset();
    mLastIdx  = -1;
    mRun      = 0;
    mErrs     = 0;
    mIdx      = 0;
    mLocked   = 1'b0;
    mIdxValid = 1'b0;
  endtask

  task automatic applyStimulus(input bit enV, input logic [3:0] ringV, input bit clrV);
    exp_t e;
    int   ones;
    int   sIdx;
    bit   oh;
    bit   pulse;
    @(negedge clk);
    en     = enV;
    ringIn = ringV;
    clrErr = clrV;
    pulse  = 1'b0;
    if (enV) begin
      ones = $countones(ringV);
      oh   = (ones == 1);
      sIdx = 0;
      for (int i = 0; i < W; i++) if (ringV[i]) sIdx = i;
      mIdxValid = oh;
      if (oh) mIdx = sIdx;
      if (mLastIdx >= 0 && oh && sIdx == (mLastIdx + 1) % W) begin
        mRun++;
        mLastIdx = sIdx;
        if (mRun >= LC) mLocked = 1'b1;
      end else begin
        if (mLocked) begin
          pulse = 1'b1;
          mErrs++;
        end
        mLocked  = 1'b0;
        mRun     = 0;
        mLastIdx = oh ? sIdx : -1;
      end
    end
    if (clrV) mErrs = 0;
    e.idx      = mIdx;
    e.idxValid = mIdxValid;
    e.locked   = mLocked;
    e.seqErr   = pulse;
    e.err8     = minInt(mErrs, 255);
    e.err2     = minInt(mErrs, 3);
    expQ.push_back(e);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, " idxA"},      int'(idxA), 0);
    checkOutput({tag, " idxValidA"}, int'(idxValidA), 0);
    checkOutput({tag, " lockedA"},   int'(lockedA), 0);
    checkOutput({tag, " seqErrA"},   int'(seqErrA), 0);
    checkOutput({tag, " errCntA"},   int'(errCntA), 0);
    checkOutput({tag, " idxB"},      int'(idxB), 0);
    checkOutput({tag, " idxValidB"}, int'(idxValidB), 0);
    checkOutput({tag, " lockedB"},   int'(lockedB), 0);
    checkOutput({tag, " seqErrB"},   int'(seqErrB), 0);
    checkOutput({tag, " errCntB"},   int'(errCntB), 0);
  endtask

  // Drop reset between clock edges and confirm the outputs clear before the next edge.
  task automatic pulseReset(input string tag);
    @(negedge clk);
    en     = 1'b0;
    clrErr = 1'b0;
    #2;
    rstn = 1'b0;
    #1;
    checkAllZero(tag);
    @(negedge clk);
    rstn = 1'b1;
    modelReset();
  endtask

  // Monitor: every edge with reset released and an expectation pending is checked.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (rstn && expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput("idxA",      int'(idxA),      e.idx);
        checkOutput("idxValidA", int'(idxValidA), int'(e.idxValid));
        checkOutput("lockedA",   int'(lockedA),   int'(e.locked));
        checkOutput("seqErrA",   int'(seqErrA),   int'(e.seqErr));
        checkOutput("errCntA",   int'(errCntA),   e.err8);
        checkOutput("idxB",      int'(idxB),      e.idx);
        checkOutput("idxValidB", int'(idxValidB), int'(e.idxValid));
        checkOutput("lockedB",   int'(lockedB),   int'(e.locked));
        checkOutput("seqErrB",   int'(seqErrB),   int'(e.seqErr));
        checkOutput("errCntB",   int'(errCntB),   e.err2);
      end
    end
  end

  initial begin
    logic [3:0] one;
    logic [3:0] ringV;
    int         genIdx;
    bit         enV;
    bit         clrV;
    int         r;

    one    = 4'b0001;
    rstn   = 1'b0;
    en     = 1'b0;
    clrErr = 1'b0;
    ringIn = 4'b0000;
    modelReset();
    #12;
    checkAllZero("reset");
    @(negedge clk);
    rstn = 1'b1;

    // Basic decode and lock acquisition.
    applyStimulus(1, 4'b0001, 0);
    applyStimulus(1, 4'b0010, 0);
    applyStimulus(1, 4'b0100, 0);
    applyStimulus(1, 4'b1000, 0);
    // Skipped step loses lock, then re-acquire.
    applyStimulus(1, 4'b0001, 0);
    applyStimulus(1, 4'b0010, 0);
    applyStimulus(1, 4'b1000, 0);
    applyStimulus(1, 4'b0001, 0);
    applyStimulus(1, 4'b0010, 0);
    applyStimulus(1, 4'b0100, 0);
    // Non-one-hot samples while locked.
    applyStimulus(1, 4'b1000, 0);
    applyStimulus(1, 4'b0110, 0);
    applyStimulus(1, 4'b0000, 0);
    // Re-lock, then garbage with sampling disabled, then resume.
    applyStimulus(1, 4'b0001, 0);
    applyStimulus(1, 4'b0010, 0);
    applyStimulus(1, 4'b0100, 0);
    applyStimulus(1, 4'b1000, 0);
    for (int i = 0; i < 5; i++) applyStimulus(0, 4'($urandom_range(0, 15)), 0);
    applyStimulus(1, 4'b0001, 0);
    applyStimulus(1, 4'b0010, 0);

    // Repeated lock losses; the 2-bit counter saturates, then a coincident clear wins.
    applyStimulus(1, 4'b0100, 1);
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1, 4'b0001, 0);
      applyStimulus(1, 4'b0010, 0);
      applyStimulus(1, 4'b0100, 0);
      applyStimulus(1, 4'b1000, 0);
      applyStimulus(1, 4'b0011, (k == 4));
    end

    // Asynchronous reset while locked, then fresh acquisition.
    applyStimulus(1, 4'b0001, 0);
    applyStimulus(1, 4'b0010, 0);
    applyStimulus(1, 4'b0100, 0);
    applyStimulus(1, 4'b1000, 0);
    pulseReset("midlock");
    applyStimulus(1, 4'b0010, 0);
    applyStimulus(1, 4'b0100, 0);
    applyStimulus(1, 4'b1000, 0);
    applyStimulus(1, 4'b0001, 0);
    applyStimulus(1, 4'b0010, 0);

    // Randomized traffic: mostly correct rotations with sporadic jumps and junk.
    genIdx = 1;
    for (int n = 0; n < 600; n++) begin
      if (n == 300) pulseReset("random");
      enV = ($urandom_range(0, 9) < 8);
      r   = $urandom_range(0, 19);
      if (r < 15) begin
        ringV = one << ((genIdx + 1) % W);
        if (enV) genIdx = (genIdx + 1) % W;
      end else if (r < 18) begin
        r     = $urandom_range(0, W - 1);
        ringV = one << r;
        if (enV) genIdx = r;
      end else begin
        ringV = 4'($urandom_range(0, 15));
      end
      clrV = enV && ($urandom_range(0, 39) == 0);
      applyStimulus(enV, ringV, clrV);
    end

    repeat (3) @(negedge clk);
    totalChecks++;
    if (expQ.size() != 0) begin
      badChecks++;
      $display("[TB] FAIL drain: got %0d pending expected 0", expQ.size());
    end
    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
